// File: rtl/sc_calib_pulse_gen_if.sv
// Connection bundle between the calibration pulse sequencer and its controller:
// configuration and request going in, injection lines and status coming out.
interface sc_calib_pulse_gen_if #(
    parameter int N_V   = 16,
    parameter int N_H   = 16,
    parameter int DLY_W = 8,
    parameter int CNT_W = 8
);
    logic             pulse_req;
    logic [4:0]       pulse_width;
    logic [DLY_W-1:0] pulse_delay;
    logic [N_V-1:0]   pulse_v_cfg;
    logic [N_H-1:0]   pulse_h_cfg;
    logic             clr_flags;
    logic [N_V-1:0]   pulse_v;
    logic [N_H-1:0]   pulse_h;
    logic             busy;
    logic             overrun;
    logic [CNT_W-1:0] pulse_count;

    modport master (
        output pulse_req, pulse_width, pulse_delay, pulse_v_cfg, pulse_h_cfg, clr_flags,
        input  pulse_v, pulse_h, busy, overrun, pulse_count
    );

    modport slave (
        input  pulse_req, pulse_width, pulse_delay, pulse_v_cfg, pulse_h_cfg, clr_flags,
        output pulse_v, pulse_h, busy, overrun, pulse_count
    );
endinterface

// File: rtl/sc_calib_pulse_gen.sv
// Calibration pulse sequencer: a rising edge on the pad request, after
// synchronization, starts a programmable delay followed by a programmable-width
// pulse on the configured V/H injection lines. Config is captured at acceptance.
module sc_calib_pulse_gen #(
    parameter int N_V   = 16,
    parameter int N_H   = 16,
    parameter int DLY_W = 8,
    parameter int CNT_W = 8
) (
    input logic                 Clk,
    input logic                 rst,
    sc_calib_pulse_gen_if.slave bus
);
    // Shared delay/width counter must hold the wider of the two loads.
    localparam int CW = (DLY_W > 5) ? DLY_W : 5;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        PULSE
    } state_t;

    state_t           state;
    logic             req_s1;
    logic             req_s2;
    logic             req_s3;
    logic             req_edge;
    logic [CW-1:0]    cnt;
    logic [4:0]       width_q;
    logic [N_V-1:0]   v_q;
    logic [N_H-1:0]   h_q;
    logic [CNT_W-1:0] count_q;

    // Two-flop synchronizer for the pad request plus one stage for edge detection
    always_ff @(posedge Clk) begin
        if (rst) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            req_s3 <= 1'b0;
        end else begin
            req_s1 <= bus.pulse_req;
            req_s2 <= req_s1;
            req_s3 <= req_s2;
        end
    end

    // Rising edge of the synchronized request
    always_comb begin
        req_edge = req_s2 & ~req_s3;
    end

    // Sequencer FSM with registered injection lines, busy, overrun and pulse counter
    always_ff @(posedge Clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            width_q     <= '0;
            v_q         <= '0;
            h_q         <= '0;
            bus.pulse_v <= '0;
            bus.pulse_h <= '0;
            bus.busy    <= 1'b0;
            bus.overrun <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_edge && (bus.pulse_width != 5'd0)) begin
                        width_q  <= bus.pulse_width;
                        v_q      <= bus.pulse_v_cfg;
                        h_q      <= bus.pulse_h_cfg;
                        bus.busy <= 1'b1;
                        if (bus.pulse_delay != '0) begin
                            state <= DELAY;
                            cnt   <= CW'(bus.pulse_delay) - CW'(1);
                        end else begin
                            state       <= PULSE;
                            cnt         <= CW'(bus.pulse_width) - CW'(1);
                            bus.pulse_v <= bus.pulse_v_cfg;
                            bus.pulse_h <= bus.pulse_h_cfg;
                        end
                    end
                end
                DELAY: begin
                    if (cnt == '0) begin
                        state       <= PULSE;
                        cnt         <= CW'(width_q) - CW'(1);
                        bus.pulse_v <= v_q;
                        bus.pulse_h <= h_q;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state       <= IDLE;
                        bus.pulse_v <= '0;
                        bus.pulse_h <= '0;
                        bus.busy    <= 1'b0;
                        count_q     <= count_q + CNT_W'(1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.pulse_v <= '0;
                    bus.pulse_h <= '0;
                    bus.busy    <= 1'b0;
                end
            endcase

            // Clear is applied last so it overrides a same-edge increment or overrun set.
            if (bus.clr_flags) begin
                bus.overrun <= 1'b0;
                count_q     <= '0;
            end else if (req_edge && (state != IDLE)) begin
                bus.overrun <= 1'b1;
            end
        end
    end

    // Pulse counter is exported directly from its register
    always_comb begin
        bus.pulse_count = count_q;
    end
endmodule
